// File: rtl/btn_conditioner.sv
// Push-button conditioner: 2-flop sync, press/release debounce, single-cycle command pulses.
// Optional hold-to-auto-repeat on inc/dec is enabled by defining BTN_AUTOREPEAT_EN.

module btn_channel #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_RATE     = 5000000,
    parameter int unsigned CNT_W           = 26,
    parameter bit          REPEAT_EN       = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    input  logic opp_level_i,
    output logic pulse_o,
    output logic level_o
);
    typedef enum logic [2:0] {
        IDLE,
        PRESS_DB,
        HELD,
`ifdef BTN_AUTOREPEAT_EN
        REPEAT,
`endif
        RELEASE_DB
    } state_e;

    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_inc;
    logic [1:0]       sync_q;
    logic             pulse_q;
    logic             level_q;
    logic             sample;

    assign sample  = sync_q[1];
    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + ONE;
    assign pulse_o = pulse_q;
    assign level_o = level_q;

`ifdef BTN_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RR_LAST = CNT_W'(REPEAT_RATE - 1);
    logic from_rep_q;
`else
    logic unused_cfg;
    assign unused_cfg = ^{opp_level_i, REPEAT_EN, REPEAT_DELAY, REPEAT_RATE};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            sync_q     <= '0;
            pulse_q    <= 1'b0;
            level_q    <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
            from_rep_q <= 1'b0;
`endif
        end else begin
            sync_q  <= {sync_q[0], btn_i};
            pulse_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (sample) begin
                        state_q <= PRESS_DB;
                        cnt_q   <= ONE;
                    end
                end
                PRESS_DB: begin
                    if (!sample) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == DB_LAST) begin
                        state_q <= HELD;
                        pulse_q <= 1'b1;
                        level_q <= 1'b1;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                HELD: begin
                    if (!sample) begin
                        state_q    <= RELEASE_DB;
                        cnt_q      <= ONE;
`ifdef BTN_AUTOREPEAT_EN
                        from_rep_q <= 1'b0;
                    end else if (REPEAT_EN && cnt_q == RD_LAST) begin
                        // Opposite button down: park at terminal count until it lets go.
                        if (!opp_level_i) begin
                            state_q <= REPEAT;
                            pulse_q <= 1'b1;
                            cnt_q   <= '0;
                        end
`endif
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
`ifdef BTN_AUTOREPEAT_EN
                REPEAT: begin
                    if (!sample) begin
                        state_q    <= RELEASE_DB;
                        cnt_q      <= ONE;
                        from_rep_q <= 1'b1;
                    end else if (cnt_q == RR_LAST) begin
                        if (!opp_level_i) begin
                            pulse_q <= 1'b1;
                            cnt_q   <= '0;
                        end
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
`endif
                RELEASE_DB: begin
                    if (sample) begin
`ifdef BTN_AUTOREPEAT_EN
                        state_q <= from_rep_q ? REPEAT : HELD;
`else
                        state_q <= HELD;
`endif
                        cnt_q   <= '0;
                    end else if (cnt_q == DB_LAST) begin
                        state_q <= IDLE;
                        level_q <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end
endmodule

module btn_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_RATE     = 5000000,
    parameter int unsigned CNT_W           = 26
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_dec,
    input  logic btn_start,
    input  logic btn_inc,
    output logic dec_pulse,
    output logic start_pulse,
    output logic inc_pulse,
    output logic dec_level,
    output logic start_level,
    output logic inc_level
);
    // Channel order: 0 = dec, 1 = start, 2 = inc.
    localparam logic [2:0] REP_MASK = 3'b101;

    logic [2:0] btn_w, pulse_w, level_w, opp_w;

    assign btn_w = {btn_inc, btn_start, btn_dec};
    assign opp_w = {level_w[0], 1'b0, level_w[2]};

    for (genvar i = 0; i < 3; i++) begin : g_ch
        btn_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_RATE    (REPEAT_RATE),
            .CNT_W          (CNT_W),
            .REPEAT_EN      (REP_MASK[i])
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .btn_i      (btn_w[i]),
            .opp_level_i(opp_w[i]),
            .pulse_o    (pulse_w[i]),
            .level_o    (level_w[i])
        );
    end

    // Simultaneous inc and dec cancel each other; start is never masked.
    assign dec_pulse   = pulse_w[0] & ~pulse_w[2];
    assign inc_pulse   = pulse_w[2] & ~pulse_w[0];
    assign start_pulse = pulse_w[1];
    assign dec_level   = level_w[0];
    assign start_level = level_w[1];
    assign inc_level   = level_w[2];
endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench for btn_conditioner: stimulus queues expected pulse cycles,
// a negedge monitor compares every cycle where a pulse is expected or seen.
module tb_btn_conditioner;
    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RR = 5;

    typedef struct {
        int ch;   // 0 dec, 1 start, 2 inc
        int cyc;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_dec = 1'b0, btn_start = 1'b0, btn_inc = 1'b0;
    logic dec_pulse, start_pulse, inc_pulse;
    logic dec_level, start_level, inc_level;

    int  cyc    = 0;
    int  checks = 0;
    int  errors = 0;
    ev_t exp_q[$];

    btn_conditioner #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_RATE    (RR),
        .CNT_W          (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_dec    (btn_dec),
        .btn_start  (btn_start),
        .btn_inc    (btn_inc),
        .dec_pulse  (dec_pulse),
        .start_pulse(start_pulse),
        .inc_pulse  (inc_pulse),
        .dec_level  (dec_level),
        .start_level(start_level),
        .inc_level  (inc_level)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : mon
        logic [2:0] exp_v, obs_v;
        ev_t ev;
        exp_v = '0;
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            ev = exp_q.pop_front();
            if (ev.cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL stale_expect ch=%0d cyc=%0d now=%0d", ev.ch, ev.cyc, cyc);
            end else begin
                exp_v[ev.ch] = 1'b1;
            end
        end
        obs_v = {inc_pulse, start_pulse, dec_pulse};
        if (exp_v != 3'b000 || obs_v != 3'b000) begin
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL pulses cyc=%0d got {inc,start,dec}=%b want %b", cyc, obs_v, exp_v);
            end
        end
    end

    task automatic go_to(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string nm, input logic act, input logic want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s cyc=%0d got %b want %b", nm, cyc, act, want);
        end
    endtask

    task automatic chk_empty(input string nm);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s pending_pulses got %0d want 0", nm, exp_q.size());
        end
    endtask

    task automatic expect_pulse(input int ch, input int c);
        ev_t ev;
        ev.ch  = ch;
        ev.cyc = c;
        exp_q.push_back(ev);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1);
    end

    initial begin
        int t0;
        int t1;

        // Reset held with all buttons high: nothing may come out.
        btn_dec = 1'b1; btn_start = 1'b1; btn_inc = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("rst_dec_level", dec_level, 1'b0);
            chk("rst_start_level", start_level, 1'b0);
            chk("rst_inc_level", inc_level, 1'b0);
        end
        rst = 1'b0;
        t0 = cyc;
        expect_pulse(1, t0 + 6);    // inc/dec coincide and cancel
        go_to(t0 + 5);
        chk("rst_start_level_pre", start_level, 1'b0);
        go_to(t0 + 6);
        chk("rst_start_level_on", start_level, 1'b1);
        chk("rst_inc_level_on", inc_level, 1'b1);
        chk("rst_dec_level_on", dec_level, 1'b1);
        go_to(t0 + 10);
        btn_dec = 1'b0; btn_start = 1'b0; btn_inc = 1'b0;
        go_to(t0 + 15);
        chk("rst_start_level_rel", start_level, 1'b1);
        go_to(t0 + 16);
        chk("rst_start_level_off", start_level, 1'b0);
        chk("rst_inc_level_off", inc_level, 1'b0);
        chk("rst_dec_level_off", dec_level, 1'b0);
        go_to(t0 + 22);
        chk_empty("after_reset");

        // Clean press/release of start.
        t0 = cyc;
        btn_start = 1'b1;
        expect_pulse(1, t0 + 6);
        go_to(t0 + 5);
        chk("clean_level_pre", start_level, 1'b0);
        go_to(t0 + 6);
        chk("clean_level_on", start_level, 1'b1);
        go_to(t0 + 40);
        btn_start = 1'b0;
        go_to(t0 + 45);
        chk("clean_level_held", start_level, 1'b1);
        go_to(t0 + 46);
        chk("clean_level_off", start_level, 1'b0);
        chk("clean_inc_level", inc_level, 1'b0);
        go_to(t0 + 55);
        chk_empty("clean");

        // Release bounce on start returns to HELD without a new pulse.
        t0 = cyc;
        btn_start = 1'b1;
        expect_pulse(1, t0 + 6);
        go_to(t0 + 20);
        btn_start = 1'b0;
        go_to(t0 + 22);
        btn_start = 1'b1;
        go_to(t0 + 30);
        chk("relbounce_level", start_level, 1'b1);
        go_to(t0 + 40);
        btn_start = 1'b0;
        go_to(t0 + 46);
        chk("relbounce_level_off", start_level, 1'b0);
        go_to(t0 + 52);
        chk_empty("relbounce");

        // Press bounce on inc restarts the debounce.
        t0 = cyc;
        btn_inc = 1'b1;
        expect_pulse(2, t0 + 10);
        go_to(t0 + 3);
        btn_inc = 1'b0;
        go_to(t0 + 4);
        btn_inc = 1'b1;
        go_to(t0 + 9);
        chk("bounce_level_pre", inc_level, 1'b0);
        go_to(t0 + 10);
        chk("bounce_level_on", inc_level, 1'b1);
        go_to(t0 + 12);
        btn_inc = 1'b0;
        go_to(t0 + 25);
        chk("bounce_level_off", inc_level, 1'b0);
        chk_empty("bounce");

        // Hold inc: press pulse, then repeats (if enabled).
        t0 = cyc;
        btn_inc = 1'b1;
        expect_pulse(2, t0 + 6);
`ifdef BTN_AUTOREPEAT_EN
        expect_pulse(2, t0 + 26);
        expect_pulse(2, t0 + 31);
        expect_pulse(2, t0 + 36);
        expect_pulse(2, t0 + 41);
        expect_pulse(2, t0 + 46);
`endif
        go_to(t0 + 47);
        btn_inc = 1'b0;
        go_to(t0 + 52);
        chk("repeat_level_held", inc_level, 1'b1);
        go_to(t0 + 53);
        chk("repeat_level_off", inc_level, 1'b0);
        go_to(t0 + 62);
        chk_empty("repeat");

        // Hold dec for 60 cycles.
        t0 = cyc;
        btn_dec = 1'b1;
        expect_pulse(0, t0 + 6);
`ifdef BTN_AUTOREPEAT_EN
        for (int k = 0; k < 8; k++) expect_pulse(0, t0 + 26 + RR * k);
`endif
        go_to(t0 + 60);
        btn_dec = 1'b0;
        go_to(t0 + 66);
        chk("dec_hold_level_off", dec_level, 1'b0);
        go_to(t0 + 72);
        chk_empty("dec_hold");

        // Conflict: inc and dec together, then dec released.
        t0 = cyc;
        btn_inc = 1'b1; btn_dec = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
        expect_pulse(2, t0 + 37);
        expect_pulse(2, t0 + 42);
        expect_pulse(2, t0 + 47);
`endif
        go_to(t0 + 6);
        chk("conf_inc_level", inc_level, 1'b1);
        chk("conf_dec_level", dec_level, 1'b1);
        go_to(t0 + 30);
        btn_dec = 1'b0;
        go_to(t0 + 35);
        chk("conf_dec_level_held", dec_level, 1'b1);
        go_to(t0 + 36);
        chk("conf_dec_level_off", dec_level, 1'b0);
        go_to(t0 + 48);
        btn_inc = 1'b0;
        go_to(t0 + 53);
        chk("conf_inc_level_held", inc_level, 1'b1);
        go_to(t0 + 54);
        chk("conf_inc_level_off", inc_level, 1'b0);
        go_to(t0 + 62);
        chk_empty("conflict");

        // Reset mid-hold, button still down after release: fresh press.
        t0 = cyc;
        btn_start = 1'b1;
        expect_pulse(1, t0 + 6);
        go_to(t0 + 8);
        chk("midrst_level_pre", start_level, 1'b1);
        rst = 1'b1;
        #1;
        chk("midrst_level_async", start_level, 1'b0);
        go_to(t0 + 10);
        rst = 1'b0;
        t1 = cyc;
        expect_pulse(1, t1 + 6);
        go_to(t1 + 5);
        chk("midrst_level_pre2", start_level, 1'b0);
        go_to(t1 + 6);
        chk("midrst_level_on2", start_level, 1'b1);
        go_to(t1 + 10);
        btn_start = 1'b0;
        go_to(t1 + 16);
        chk("midrst_level_off", start_level, 1'b0);
        go_to(t1 + 22);
        chk_empty("midrst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
